// File: rtl/mem_stage.sv
// Memory-access pipeline stage: aligned byte/half/word/dword loads and stores over a
// single-outstanding req/ack bus, with pass-through of non-memory results to writeback.
module mem_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int RNUM_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                is_ld,
   input  logic                is_str,
   input  logic [1:0]          size,
   input  logic                ld_signed,
   input  logic [ADDR_W-1:0]   md,
   input  logic [DATA_W-1:0]   rd_val,
   input  logic [RNUM_W-1:0]   rd_num,
   input  logic [DATA_W-1:0]   result,
   input  logic                wr_reg,
   output logic                mem_req,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                wb_valid,
   output logic                wb_en,
   output logic [RNUM_W-1:0]   wb_num,
   output logic [DATA_W-1:0]   wb_val,
   output logic                wb_err
);

   localparam int BE_W   = DATA_W / 8;
   localparam int LANE_W = $clog2(BE_W);

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t              state_r, state_nxt_s;
   logic [LANE_W-1:0]   off_s, align_s, off_r;
   logic [1:0]          size_r;
   logic                sgn_r, ld_r;
   logic [RNUM_W-1:0]   num_r;
   logic                accept_s, is_mem_s, bad_s, start_s;
   logic [BE_W-1:0]     st_be_s, ld_keep_s;
   logic [DATA_W-1:0]   st_data_s, ld_x_s, ld_ext_s;
   logic                ld_sign_s;

   // Low n bytes enabled, n = 1 << sz.
   function automatic logic [BE_W-1:0] lane_be(input logic [1:0] sz);
      logic [BE_W-1:0] be;
      be = '0;
      for (int i = 0; i < BE_W; i++) begin
         be[i] = (i < int'(32'd1 << sz));
      end
      return be;
   endfunction

   // Expand byte enables to a bit mask.
   function automatic logic [DATA_W-1:0] be_mask(input logic [BE_W-1:0] be);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int i = 0; i < BE_W; i++) begin
         m[8*i +: 8] = {8{be[i]}};
      end
      return m;
   endfunction

   assign in_ready = (state_r == IDLE);

   // Request decode: alignment, legality and store lane placement.
   always_comb begin
      off_s     = md[LANE_W-1:0];
      align_s   = LANE_W'((32'd1 << size) - 32'd1);
      accept_s  = in_valid & (state_r == IDLE);
      is_mem_s  = is_ld | is_str;
      bad_s     = (|(off_s & align_s)) | (is_ld & is_str) | ((size == 2'd3) && (DATA_W == 32));
      start_s   = accept_s & is_mem_s & ~bad_s;
      st_be_s   = lane_be(size) << off_s;
      st_data_s = (rd_val & be_mask(lane_be(size))) << {off_s, 3'b000};
   end

   // Load alignment and sign/zero extension of the captured lane.
   always_comb begin
      ld_keep_s = lane_be(size_r);
      ld_x_s    = mem_rdata >> {off_r, 3'b000};
      ld_sign_s = 1'b0;
      ld_ext_s  = '0;
      for (int i = 0; i < BE_W; i++) begin
         if (ld_keep_s[i]) ld_sign_s = ld_x_s[8*i+7];
         else              ld_sign_s = ld_sign_s;
      end
      for (int i = 0; i < BE_W; i++) begin
         if (ld_keep_s[i]) ld_ext_s[8*i +: 8] = ld_x_s[8*i +: 8];
         else              ld_ext_s[8*i +: 8] = {8{sgn_r & ld_sign_s}};
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_nxt_s;
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_s) state_nxt_s = BUSY;
            else         state_nxt_s = IDLE;
         end
         BUSY: begin
            if (mem_ack) state_nxt_s = IDLE;
            else         state_nxt_s = BUSY;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Bus and writeback output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_wdata <= '0;
         wb_valid  <= 1'b0;
         wb_en     <= 1'b0;
         wb_num    <= '0;
         wb_val    <= '0;
         wb_err    <= 1'b0;
         off_r     <= '0;
         size_r    <= 2'd0;
         sgn_r     <= 1'b0;
         ld_r      <= 1'b0;
         num_r     <= '0;
      end else begin
         wb_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s && !is_mem_s) begin
                  wb_valid <= 1'b1;
                  wb_en    <= wr_reg;
                  wb_num   <= rd_num;
                  wb_val   <= result;
                  wb_err   <= 1'b0;
               end else if (accept_s && bad_s) begin
                  wb_valid <= 1'b1;
                  wb_en    <= 1'b0;
                  wb_num   <= rd_num;
                  wb_val   <= '0;
                  wb_err   <= 1'b1;
               end else if (start_s) begin
                  mem_req   <= 1'b1;
                  mem_addr  <= {md[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
                  mem_we    <= is_str;
                  mem_be    <= st_be_s;
                  mem_wdata <= is_str ? st_data_s : '0;
                  off_r     <= off_s;
                  size_r    <= size;
                  sgn_r     <= ld_signed;
                  ld_r      <= is_ld;
                  num_r     <= rd_num;
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  wb_valid <= 1'b1;
                  wb_en    <= ld_r;
                  wb_num   <= num_r;
                  wb_val   <= ld_r ? ld_ext_s : '0;
                  wb_err   <= 1'b0;
               end
            end
            default: mem_req <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a 32-bit and a 64-bit instance share stimulus, selected by sel64.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n, sel64, in_valid, is_ld, is_str, ld_signed, wr_reg, mem_ack;
   logic [1:0]  size;
   logic [31:0] md;
   logic [63:0] rd_val, result, mem_rdata;
   logic [3:0]  rd_num;

   logic        rdy_a, req_a, we_a, wbv_a, wben_a, wberr_a;
   logic [31:0] addr_a, wdata_a, wbval_a;
   logic [3:0]  be_a, wbnum_a;
   logic        rdy_b, req_b, we_b, wbv_b, wben_b, wberr_b;
   logic [31:0] addr_b;
   logic [63:0] wdata_b, wbval_b;
   logic [7:0]  be_b;
   logic [3:0]  wbnum_b;

   logic        o_ready, o_req, o_we, o_wbv, o_wben, o_wberr;
   logic [31:0] o_addr;
   logic [7:0]  o_be;
   logic [63:0] o_wdata, o_wbval;
   logic [3:0]  o_wbnum;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_stage #(.DATA_W(32), .ADDR_W(32), .RNUM_W(4)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel64), .in_ready(rdy_a),
      .is_ld(is_ld), .is_str(is_str), .size(size), .ld_signed(ld_signed), .md(md),
      .rd_val(rd_val[31:0]), .rd_num(rd_num), .result(result[31:0]), .wr_reg(wr_reg),
      .mem_req(req_a), .mem_addr(addr_a), .mem_we(we_a), .mem_be(be_a), .mem_wdata(wdata_a),
      .mem_ack(mem_ack & ~sel64), .mem_rdata(mem_rdata[31:0]),
      .wb_valid(wbv_a), .wb_en(wben_a), .wb_num(wbnum_a), .wb_val(wbval_a), .wb_err(wberr_a));

   mem_stage #(.DATA_W(64), .ADDR_W(32), .RNUM_W(4)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel64), .in_ready(rdy_b),
      .is_ld(is_ld), .is_str(is_str), .size(size), .ld_signed(ld_signed), .md(md),
      .rd_val(rd_val), .rd_num(rd_num), .result(result), .wr_reg(wr_reg),
      .mem_req(req_b), .mem_addr(addr_b), .mem_we(we_b), .mem_be(be_b), .mem_wdata(wdata_b),
      .mem_ack(mem_ack & sel64), .mem_rdata(mem_rdata),
      .wb_valid(wbv_b), .wb_en(wben_b), .wb_num(wbnum_b), .wb_val(wbval_b), .wb_err(wberr_b));

   assign o_ready = sel64 ? rdy_b   : rdy_a;
   assign o_req   = sel64 ? req_b   : req_a;
   assign o_we    = sel64 ? we_b    : we_a;
   assign o_wbv   = sel64 ? wbv_b   : wbv_a;
   assign o_wben  = sel64 ? wben_b  : wben_a;
   assign o_wberr = sel64 ? wberr_b : wberr_a;
   assign o_addr  = sel64 ? addr_b  : addr_a;
   assign o_be    = sel64 ? be_b    : {4'h0, be_a};
   assign o_wdata = sel64 ? wdata_b : {32'h0, wdata_a};
   assign o_wbval = sel64 ? wbval_b : {32'h0, wbval_a};
   assign o_wbnum = sel64 ? wbnum_b : wbnum_a;

   typedef struct {
      logic        w64, ld, st;
      logic [1:0]  sz;
      logic        sg, wr;
      logic [3:0]  num;
      logic [31:0] a;
      logic [63:0] wd, rdat, res;
      int          dly;
      logic        e_mem, e_err, e_en;
      logic [31:0] e_addr;
      logic [7:0]  e_be;
      logic [63:0] e_wdata, e_val;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic w64, input logic ld, input logic st, input logic [1:0] sz,
                      input logic sg, input logic wr, input logic [3:0] num, input logic [31:0] a,
                      input logic [63:0] wd, input logic [63:0] rdat, input logic [63:0] res,
                      input int dly, input logic e_mem, input logic e_err, input logic e_en,
                      input logic [31:0] e_addr, input logic [7:0] e_be,
                      input logic [63:0] e_wdata, input logic [63:0] e_val);
      vec_t v;
      v.w64 = w64; v.ld = ld; v.st = st; v.sz = sz; v.sg = sg; v.wr = wr; v.num = num;
      v.a = a; v.wd = wd; v.rdat = rdat; v.res = res; v.dly = dly; v.e_mem = e_mem;
      v.e_err = e_err; v.e_en = e_en; v.e_addr = e_addr; v.e_be = e_be;
      v.e_wdata = e_wdata; v.e_val = e_val;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      sel64 = v.w64;
      #1;
      chk("idle_ready", {63'h0, o_ready}, 64'h1);
      chk("wb_pulse_done", {63'h0, o_wbv}, 64'h0);
      is_ld = v.ld; is_str = v.st; size = v.sz; ld_signed = v.sg; wr_reg = v.wr;
      rd_num = v.num; md = v.a; rd_val = v.wd; result = v.res;
      mem_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      if (v.e_mem) begin
         chk("req_on", {63'h0, o_req}, 64'h1);
         chk("addr", {32'h0, o_addr}, {32'h0, v.e_addr});
         chk("be", {56'h0, o_be}, {56'h0, v.e_be});
         chk("we", {63'h0, o_we}, {63'h0, v.st});
         chk("wdata", o_wdata, v.e_wdata);
         chk("busy_ready", {63'h0, o_ready}, 64'h0);
         for (int c = 1; c < v.dly; c++) begin
            @(negedge clk);
            chk("req_hold", {63'h0, o_req}, 64'h1);
            chk("be_hold", {56'h0, o_be}, {56'h0, v.e_be});
            chk("busy_ready_hold", {63'h0, o_ready}, 64'h0);
            chk("no_early_wb", {63'h0, o_wbv}, 64'h0);
         end
         mem_rdata = v.rdat;
         mem_ack   = 1'b1;
         @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
         chk("req_off", {63'h0, o_req}, 64'h0);
         chk("ready_back", {63'h0, o_ready}, 64'h1);
      end else begin
         chk("no_req", {63'h0, o_req}, 64'h0);
      end
      chk("wb_valid", {63'h0, o_wbv}, 64'h1);
      chk("wb_err", {63'h0, o_wberr}, {63'h0, v.e_err});
      chk("wb_en", {63'h0, o_wben}, {63'h0, v.e_en});
      if (!v.e_err) begin
         chk("wb_num", {60'h0, o_wbnum}, {60'h0, v.num});
         chk("wb_val", o_wbval, v.e_val);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; sel64 = 1'b0; in_valid = 1'b0; is_ld = 1'b0; is_str = 1'b0;
      ld_signed = 1'b0; wr_reg = 1'b0; mem_ack = 1'b0; size = 2'd0; md = 32'h0;
      rd_val = 64'h0; result = 64'h0; mem_rdata = 64'h0; rd_num = 4'd0;

      //   w64 ld st sz sg wr num addr wd rdat res dly | mem err en e_addr e_be e_wdata e_val
      add(0,0,0,2'd0,0,1,4'd5,32'h0,   64'h0, 64'h0, 64'h1234, 1, 0,0,1, 32'h0,   8'h0, 64'h0, 64'h1234);
      add(0,0,0,2'd0,0,0,4'd3,32'h0,   64'h0, 64'h0, 64'hCAFE, 1, 0,0,0, 32'h0,   8'h0, 64'h0, 64'hCAFE);
      add(0,0,1,2'd0,0,0,4'd2,32'h103, 64'hAB, 64'h0, 64'h0, 2, 1,0,0, 32'h100, 8'h8, 64'hAB000000, 64'h0);
      add(0,0,1,2'd0,0,0,4'd2,32'h101, 64'hFFFFFFAB, 64'h0, 64'h0, 1, 1,0,0, 32'h100, 8'h2, 64'h0000AB00, 64'h0);
      add(0,0,1,2'd1,0,0,4'd2,32'h102, 64'h1234BEEF, 64'h0, 64'h0, 1, 1,0,0, 32'h100, 8'hC, 64'hBEEF0000, 64'h0);
      add(0,0,1,2'd2,0,0,4'd2,32'h200, 64'hDEADBEEF, 64'h0, 64'h0, 3, 1,0,0, 32'h200, 8'hF, 64'hDEADBEEF, 64'h0);
      add(0,1,0,2'd1,1,0,4'd7,32'h102, 64'h0, 64'h80015A5A, 64'h0, 1, 1,0,1, 32'h100, 8'hC, 64'h0, 64'hFFFF8001);
      add(0,1,0,2'd1,0,0,4'd7,32'h102, 64'h0, 64'h80015A5A, 64'h0, 2, 1,0,1, 32'h100, 8'hC, 64'h0, 64'h00008001);
      add(0,1,0,2'd0,1,0,4'd8,32'h101, 64'h0, 64'h00007F00, 64'h0, 1, 1,0,1, 32'h100, 8'h2, 64'h0, 64'h0000007F);
      add(0,1,0,2'd0,1,0,4'd8,32'h100, 64'h0, 64'h000000F0, 64'h0, 3, 1,0,1, 32'h100, 8'h1, 64'h0, 64'hFFFFFFF0);
      add(0,1,0,2'd2,1,0,4'd9,32'h104, 64'h0, 64'h89ABCDEF, 64'h0, 1, 1,0,1, 32'h104, 8'hF, 64'h0, 64'h89ABCDEF);
      add(0,1,0,2'd2,0,0,4'd1,32'h102, 64'h0, 64'h0, 64'h0, 1, 0,1,0, 32'h0, 8'h0, 64'h0, 64'h0);
      add(0,1,0,2'd3,0,0,4'd1,32'h100, 64'h0, 64'h0, 64'h0, 1, 0,1,0, 32'h0, 8'h0, 64'h0, 64'h0);
      add(0,0,1,2'd1,0,0,4'd1,32'h101, 64'h0, 64'h0, 64'h0, 1, 0,1,0, 32'h0, 8'h0, 64'h0, 64'h0);
      add(0,1,1,2'd0,0,0,4'd1,32'h100, 64'h0, 64'h0, 64'h0, 1, 0,1,0, 32'h0, 8'h0, 64'h0, 64'h0);
      add(1,0,1,2'd3,0,0,4'd4,32'h08, 64'h1122334455667788, 64'h0, 64'h0, 1, 1,0,0, 32'h08, 8'hFF, 64'h1122334455667788, 64'h0);
      add(1,1,0,2'd2,0,0,4'd6,32'h0C, 64'h0, 64'hDEADBEEF00000000, 64'h0, 2, 1,0,1, 32'h08, 8'hF0, 64'h0, 64'h00000000DEADBEEF);
      add(1,1,0,2'd2,1,0,4'd6,32'h0C, 64'h0, 64'hDEADBEEF00000000, 64'h0, 1, 1,0,1, 32'h08, 8'hF0, 64'h0, 64'hFFFFFFFFDEADBEEF);
      add(1,1,0,2'd3,0,0,4'd6,32'h0C, 64'h0, 64'h0, 64'h0, 1, 0,1,0, 32'h0, 8'h0, 64'h0, 64'h0);
      add(1,0,1,2'd0,0,0,4'd6,32'h0F, 64'hAB, 64'h0, 64'h0, 1, 1,0,0, 32'h08, 8'h80, 64'hAB00000000000000, 64'h0);

      // reset state
      #2;
      chk("rst_ready", {63'h0, o_ready}, 64'h1);
      chk("rst_req", {63'h0, o_req}, 64'h0);
      chk("rst_be", {56'h0, o_be}, 64'h0);
      chk("rst_addr", {32'h0, o_addr}, 64'h0);
      chk("rst_wbv", {63'h0, o_wbv}, 64'h0);
      chk("rst_wbval", o_wbval, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vq[i]) run_vec(vq[i]);

      // back-to-back pass-through accepts
      @(negedge clk);
      sel64 = 1'b0; is_ld = 1'b0; is_str = 1'b0; wr_reg = 1'b1;
      rd_num = 4'd9; result = 64'h1111; in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_v0", {63'h0, o_wbv}, 64'h1);
      chk("b2b_val0", o_wbval, 64'h1111);
      chk("b2b_ready", {63'h0, o_ready}, 64'h1);
      rd_num = 4'd10; result = 64'h2222;
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_v1", {63'h0, o_wbv}, 64'h1);
      chk("b2b_num1", {60'h0, o_wbnum}, 64'd10);
      @(negedge clk);
      chk("b2b_end", {63'h0, o_wbv}, 64'h0);
      chk("wb_hold", o_wbval, 64'h2222);

      // ack while idle is ignored
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("idle_ack_wbv", {63'h0, o_wbv}, 64'h0);
      chk("idle_ack_req", {63'h0, o_req}, 64'h0);

      // reset while busy aborts the access
      is_ld = 1'b1; size = 2'd2; ld_signed = 1'b0; md = 32'h300; rd_num = 4'd11;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("abort_req_on", {63'h0, o_req}, 64'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_req_off", {63'h0, o_req}, 64'h0);
      chk("abort_ready", {63'h0, o_ready}, 64'h1);
      @(negedge clk);
      rst_n = 1'b1;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("abort_no_wb", {63'h0, o_wbv}, 64'h0);
      run_vec(vq[6]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Parametrised memory-access pipeline stage between execute and writeback. Accepts one operation per handshake from execute, performs byte/half/word/dword loads and stores with byte enables, alignment checking and sign/zero extension over a single-outstanding req/ack data-memory bus, and stalls upstream while a bus access is in flight. Non-memory operations pass through to writeback with one cycle of latency.

## Interface
- DATA_W, 32: data bus and register width; 32 or 64.
- ADDR_W, 32: byte address width.
- RNUM_W, 4: destination register number width.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  execute presents an operation.
- in_ready  out  1  stage accepts; equals (state==IDLE).
- is_ld, is_str  in  1  load / store operation.
- size  in  2  0 byte, 1 half, 2 word, 3 dword (legal only when DATA_W=64).
- ld_signed  in  1  sign-extend load result.
- md  in  ADDR_W  byte address.
- rd_val  in  DATA_W  store data, right-aligned.
- rd_num  in  RNUM_W  destination register.
- result  in  DATA_W  execute result for non-memory ops.
- wr_reg  in  1  non-memory op writes rd_num.
- mem_req  out  1  bus request, held until mem_ack.
- mem_addr  out  ADDR_W  md with lane-offset bits cleared.
- mem_we  out  1  1 store, 0 load.
- mem_be  out  DATA_W/8  byte enables.
- mem_wdata  out  DATA_W  lane-shifted store data.
- mem_ack  in  1  access complete; mem_rdata valid this cycle for loads.
- mem_rdata  in  DATA_W  read data.
- wb_valid  out  1  one-cycle pulse per retired operation.
- wb_en  out  1  register write required.
- wb_num  out  RNUM_W  destination register.
- wb_val  out  DATA_W  write value.
- wb_err  out  1  misaligned or illegal memory op; wb_en forced 0.

## Operation
- Lane offset off = md[log2(DATA_W/8)-1:0]; bytes n = 1<<size. Misaligned when off mod n != 0. Illegal when is_ld&is_str, or size=3 with DATA_W=32.
- Store: mem_be = ((1<<n)-1)<<off; mem_wdata = rd_val<<(8*off), unused lanes 0.
- Load: x = mem_rdata>>(8*off), keep low 8n bits, extend to DATA_W by bit 8n-1 if ld_signed, else zero. Loads drive mem_be as for stores, mem_wdata=0.
- FSM IDLE/BUSY. IDLE + in_valid accepted:
  - neither is_ld nor is_str: next cycle wb_valid=1, wb_en=wr_reg, wb_num=rd_num, wb_val=result; stay IDLE.
  - misaligned/illegal: next cycle wb_valid=1, wb_err=1, wb_en=0; no bus access; stay IDLE.
  - legal ld/str: register bus outputs, mem_req=1 next cycle, go BUSY.
- BUSY: mem_req and all bus outputs stable; in_ready=0. On mem_ack: mem_req=0 next cycle, return IDLE; next cycle wb_valid=1, for load wb_en=1, wb_val=extended x, wb_num=rd_num; for store wb_en=0, wb_val=0.
- mem_ack in IDLE, or a second ack, is ignored.
- Writeback never back-pressures. wb_* fields other than wb_valid hold last values between pulses.

## Timing
- Reset (async, immediate): state IDLE, mem_req/mem_we/mem_be/mem_addr/mem_wdata=0, wb_valid/wb_en/wb_err/wb_num/wb_val=0; in_ready=1 once state is IDLE. Reset mid-BUSY aborts the access with no wb pulse.
- Non-memory or error op accepted cycle 0 -> wb_valid cycle 1; back-to-back accepts give one pulse per cycle.
- Memory op accepted cycle 0 -> mem_req cycles 1..k (mem_ack at k>=1) -> wb_valid cycle k+1; in_ready=0 cycles 1..k, 1 at k+1, so next accept at k+1 at earliest.
- mem_rdata sampled only in the mem_ack cycle.

## Test plan
- ALU pass-through: result=0x1234, rd_num=5, wr_reg=1 -> next cycle wb_valid=1, wb_en=1, wb_num=5, wb_val=0x1234; mem_req stays 0.
- Byte store md=0x103, rd_val=0xAB, ack 2 cycles after req -> mem_addr=0x100, mem_be=4'b1000, mem_wdata=0xAB000000, mem_we=1 held 2 cycles; in_ready=0 during; wb_valid with wb_en=0.
- Signed half load md=0x102, mem_rdata=0x8001xxxx -> wb_val=0xFFFF8001; unsigned repeat -> 0x00008001; byte signed md=0x101, rdata=0x00007F00 -> 0x0000007F.
- Misaligned word load md=0x102 -> no mem_req, next cycle wb_valid=1, wb_err=1, wb_en=0; size=3 at DATA_W=32 likewise.
- DATA_W=64: dword store md=0x08 -> mem_be=8'hFF; word load md=0x0C, rdata=0xDEADBEEF_00000000 -> wb_val=0x00000000DEADBEEF.
- rst_n low while BUSY -> mem_req drops immediately, no wb_valid; after release, a load completes normally.
